vga_screen_arbiter: RTL and testbench
=====================================

Name: vga_screen_arbiter

Overview:
Parametrised N-source VGA screen selector for the game's top level. It replaces the combinational priority mux of per-screen VGA outputs (title, countdown, pause, gameplay, win A/B, ...). Requested screens are prioritised by index, and the switch is deferred to a vertical-sync boundary so frames never tear. All VGA outputs are registered. An optional fade-to-black transition is available. It sits between the screen generators and the board VGA pins.

Parameters:
NUM_SRC, 8, number of screen sources; index 0 has highest priority.
COLOR_W, 8, bits per colour channel.
FADE_FRAMES, 16, frames per fade half (power of 2, 2..64); used only with the fade feature.

Ports:
CLOCK_50  in  1  system clock, 50 MHz
resetn  in  1  asynchronous active-low reset
src_req  in  NUM_SRC  per-source enable/request (e.g. enable_title_screen, game_active)
src_r  in  NUM_SRC*COLOR_W  red per source; source i occupies bits [i*COLOR_W +: COLOR_W]
src_g  in  NUM_SRC*COLOR_W  green per source; same packing
src_b  in  NUM_SRC*COLOR_W  blue per source; same packing
src_hs  in  NUM_SRC  hsync per source, active low
src_vs  in  NUM_SRC  vsync per source, active low
src_blank_n  in  NUM_SRC  blank_n per source
src_sync_n  in  NUM_SRC  sync_n per source
VGA_R / VGA_G / VGA_B  out  COLOR_W each  registered colour
VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N  out  1 each  registered timing
active_sel  out  clog2(NUM_SRC)  index of the source currently displayed
sel_valid  out  1  1 when a source is displayed; 0 when the output is black idle
switch_pending  out  1  1 while a selection change is waiting or fading

Behaviour:
- Reset (async, resetn=0):
  - RGB = 0, VGA_HS = 1, VGA_VS = 1, VGA_BLANK_N = 0, VGA_SYNC_N = 0.
  - active_sel = 0, sel_valid = 0, switch_pending = 0, FSM = SHOW.
- Target: lowest set index of src_req, recomputed every cycle. When src_req = 0, the target is "none".
- Timing source:
  - When sel_valid = 1, timing comes from src_*[active_sel].
  - When sel_valid = 0, timing comes from source 0 and RGB is forced to 0.
- Frame boundary: a falling edge of the timing source's vs, detected from a registered copy of vs. The edge is evaluated every cycle.
- FSM states without the fade feature:
  - SHOW: if target ≠ current selection (sel_valid included in the comparison), go to WAIT_VS and set switch_pending = 1.
  - WAIT_VS: on a frame boundary, load active_sel/sel_valid from the target at that cycle and return to SHOW. switch_pending clears on the same edge.
  - WAIT_VS: if the target equals the current selection again before the boundary, cancel, return to SHOW and clear switch_pending.
- Output latency: exactly 1 CLOCK_50 cycle from the src_* inputs to VGA_*. RGB, HS, VS, BLANK_N and SYNC_N share the same pipeline register, so they stay aligned.
- The swap is applied on the boundary cycle itself. The first output cycle after the boundary edge already carries the new source.
- Target changes during WAIT_VS (A→B pending, then C requested) retarget to C and do not restart the wait.
- VGA_CLK is not handled by this block; the top level drives it from the shared 25 MHz pixel enable.

Optional Feature:
Macro VGA_ARB_FADE_EN.
- Defined: switching uses the states SHOW → FADE_OUT → SWAP → FADE_IN → SHOW.
  - A level counter runs from FADE_FRAMES down to 0, decrementing 1 per frame boundary, in FADE_OUT.
  - SWAP loads the target at the next boundary.
  - FADE_IN counts from 0 back to FADE_FRAMES.
  - Output colour = (src_colour * level) >> log2(FADE_FRAMES), computed per channel with a COLOR_W + 7 bit intermediate, truncated to COLOR_W.
  - If the target reverts to the current source during FADE_OUT, enter FADE_IN from the current level.
  - A target change during FADE_IN goes straight to FADE_OUT from the current level.
  - switch_pending = 1 from leaving SHOW until the level reaches FADE_FRAMES in FADE_IN.
  - The fade is applied in the same output register, so latency stays 1 cycle.
- Undefined: no level counter or multiplier; the behaviour is the plain WAIT_VS version above.

Test Plan:
1. Reset with src_req=8'h00 → VGA_R/G/B = 0, VGA_BLANK_N = 0, sel_valid = 0; after release, HS/VS follow src_hs[0]/src_vs[0] one cycle late with RGB = 0.
2. Set src_req=8'h04 with src_r[2]=8'hAA mid-frame → switch_pending=1 and no change until the src_vs[0] falling edge. The next cycle shows active_sel=2, VGA_R=8'hAA, switch_pending=0.
3. src_req=8'h14 → source 2 displayed (priority); drop bit 2 → switch to source 4 at the next src_vs[2] falling edge only.
4. Request toggles 2→5→2 within one frame → no swap, active_sel stays 2, switch_pending returns to 0, no output glitch.
5. Assert resetn=0 mid-WAIT_VS → outputs return to reset values immediately, asynchronously to CLOCK_50.
6. With VGA_ARB_FADE_EN, FADE_FRAMES=4, source colour 8'hFF → VGA_R steps 8'hFF, BF, 7F, 3F, 00 on successive frames, then the new source at 00, 3F, 7F, BF, FF; switch_pending stays high across all 8 boundaries.

Source files
------------

// File: rtl/vga_screen_arbiter_if.sv
// Bus bundle for vga_screen_arbiter: the per-source screen generator signals
// going in, and the board VGA pins plus selection status coming out.
// master: the side that drives the screen sources (top level / bench).
// slave : the arbiter itself.
interface vga_screen_arbiter_if #(
    parameter int NUM_SRC = 8,
    parameter int COLOR_W = 8
);
    localparam int SEL_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    // Per-source inputs, source i packed at [i*COLOR_W +: COLOR_W]
    logic [NUM_SRC-1:0]         src_req;
    logic [NUM_SRC*COLOR_W-1:0] src_r;
    logic [NUM_SRC*COLOR_W-1:0] src_g;
    logic [NUM_SRC*COLOR_W-1:0] src_b;
    logic [NUM_SRC-1:0]         src_hs;
    logic [NUM_SRC-1:0]         src_vs;
    logic [NUM_SRC-1:0]         src_blank_n;
    logic [NUM_SRC-1:0]         src_sync_n;

    // Registered VGA outputs and selection status
    logic [COLOR_W-1:0]         VGA_R;
    logic [COLOR_W-1:0]         VGA_G;
    logic [COLOR_W-1:0]         VGA_B;
    logic                       VGA_HS;
    logic                       VGA_VS;
    logic                       VGA_BLANK_N;
    logic                       VGA_SYNC_N;
    logic [SEL_W-1:0]           active_sel;
    logic                       sel_valid;
    logic                       switch_pending;

    modport master (
        output src_req, src_r, src_g, src_b, src_hs, src_vs, src_blank_n, src_sync_n,
        input  VGA_R, VGA_G, VGA_B, VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N,
        input  active_sel, sel_valid, switch_pending
    );

    modport slave (
        input  src_req, src_r, src_g, src_b, src_hs, src_vs, src_blank_n, src_sync_n,
        output VGA_R, VGA_G, VGA_B, VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N,
        output active_sel, sel_valid, switch_pending
    );
endinterface

// File: rtl/vga_screen_arbiter.sv
// vga_screen_arbiter: N-source VGA screen selector.
// Picks the lowest-index requesting source and only switches on a falling
// edge of the displayed source's vsync, so frames never tear. All VGA
// outputs come from one register stage (1 cycle latency, aligned timing).
// Optional fade-to-black transition: define VGA_ARB_FADE_EN.
module vga_screen_arbiter #(
    parameter int NUM_SRC     = 8,
    parameter int COLOR_W     = 8,
    parameter int FADE_FRAMES = 16
) (
    input  logic                 CLOCK_50,
    input  logic                 resetn,
    vga_screen_arbiter_if.slave  bus
);
    localparam int SEL_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    if ((FADE_FRAMES < 2) || (FADE_FRAMES > 64) ||
        ((FADE_FRAMES & (FADE_FRAMES - 1)) != 0)) begin : g_fade_cfg_bad
        $error("vga_screen_arbiter: FADE_FRAMES must be a power of two in 2..64");
    end

`ifdef VGA_ARB_FADE_EN
    localparam int             LVL_W    = 7;
    localparam int             FADE_SH  = $clog2(FADE_FRAMES);
    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(FADE_FRAMES);

    typedef enum logic [1:0] {
        ST_SHOW     = 2'd0,
        ST_FADE_OUT = 2'd1,
        ST_SWAP     = 2'd2,
        ST_FADE_IN  = 2'd3
    } state_e;

    // Scale one colour channel by level/FADE_FRAMES (COLOR_W+7 bit product)
    function automatic logic [COLOR_W-1:0] fade_scale(
        input logic [COLOR_W-1:0] c,
        input logic [LVL_W-1:0]   lvl
    );
        logic [COLOR_W+6:0] prod;
        prod = (COLOR_W+7)'(c) * (COLOR_W+7)'(lvl);
        return COLOR_W'(prod >> FADE_SH);
    endfunction

    logic [LVL_W-1:0] level_r;
    logic [LVL_W-1:0] level_nxt_s;
`else
    typedef enum logic [1:0] {
        ST_SHOW    = 2'd0,
        ST_WAIT_VS = 2'd1
    } state_e;
`endif

    // Selection state
    state_e             state_r;
    logic [SEL_W-1:0]   active_sel_r;
    logic               sel_valid_r;
    logic               switch_pending_r;
    logic               vs_prev_r;

    // Output pipeline registers
    logic [COLOR_W-1:0] vga_r_r;
    logic [COLOR_W-1:0] vga_g_r;
    logic [COLOR_W-1:0] vga_b_r;
    logic               vga_hs_r;
    logic               vga_vs_r;
    logic               vga_blank_n_r;
    logic               vga_sync_n_r;

    // Combinational decisions
    logic [SEL_W-1:0]   target_idx_s;
    logic               target_valid_s;
    logic               differ_s;
    logic [SEL_W-1:0]   time_idx_s;
    logic               boundary_s;
    logic               swap_now_s;
    logic               out_valid_s;
    logic [SEL_W-1:0]   src_idx_s;
    logic [COLOR_W-1:0] pix_r_s;
    logic [COLOR_W-1:0] pix_g_s;
    logic [COLOR_W-1:0] pix_b_s;
    logic               pix_hs_s;
    logic               pix_vs_s;
    logic               pix_blank_n_s;
    logic               pix_sync_n_s;
    logic [COLOR_W-1:0] out_r_s;
    logic [COLOR_W-1:0] out_g_s;
    logic [COLOR_W-1:0] out_b_s;

    // Priority encoder: lowest requesting index wins, none when src_req is 0
    always_comb begin
        target_idx_s   = '0;
        target_valid_s = 1'b0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            target_idx_s   = bus.src_req[i] ? SEL_W'(i) : target_idx_s;
            target_valid_s = bus.src_req[i] | target_valid_s;
        end
    end

    // Compare target with the current selection and find the frame boundary
    always_comb begin
        differ_s   = (target_valid_s != sel_valid_r) ||
                     (target_valid_s && (target_idx_s != active_sel_r));
        time_idx_s = sel_valid_r ? active_sel_r : '0;
        boundary_s = vs_prev_r & ~bus.src_vs[time_idx_s];
    end

`ifdef VGA_ARB_FADE_EN
    // Swap timing and the level the output register will use this cycle
    always_comb begin
        swap_now_s  = (state_r == ST_SWAP) && boundary_s;
        level_nxt_s = level_r;
        case (state_r)
            ST_SHOW: begin
                level_nxt_s = LVL_FULL;
            end
            ST_FADE_OUT: begin
                if (differ_s && boundary_s && (level_r != 7'd0)) begin
                    level_nxt_s = level_r - 7'd1;
                end else begin
                    level_nxt_s = level_r;
                end
            end
            ST_FADE_IN: begin
                if (!differ_s && boundary_s && (level_r != LVL_FULL)) begin
                    level_nxt_s = level_r + 7'd1;
                end else begin
                    level_nxt_s = level_r;
                end
            end
            default: begin
                level_nxt_s = level_r;
            end
        endcase
    end
`else
    // Swap happens on the boundary cycle while a change is waiting
    always_comb begin
        swap_now_s = (state_r == ST_WAIT_VS) && differ_s && boundary_s;
    end
`endif

    // Pick the source feeding the output register (new source on swap cycle)
    always_comb begin
        out_valid_s   = swap_now_s ? target_valid_s : sel_valid_r;
        src_idx_s     = out_valid_s ? (swap_now_s ? target_idx_s : active_sel_r) : '0;
        pix_r_s       = '0;
        pix_g_s       = '0;
        pix_b_s       = '0;
        pix_hs_s      = 1'b1;
        pix_vs_s      = 1'b1;
        pix_blank_n_s = 1'b0;
        pix_sync_n_s  = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (SEL_W'(i) == src_idx_s) begin
                pix_r_s       = bus.src_r[i*COLOR_W +: COLOR_W];
                pix_g_s       = bus.src_g[i*COLOR_W +: COLOR_W];
                pix_b_s       = bus.src_b[i*COLOR_W +: COLOR_W];
                pix_hs_s      = bus.src_hs[i];
                pix_vs_s      = bus.src_vs[i];
                pix_blank_n_s = bus.src_blank_n[i];
                pix_sync_n_s  = bus.src_sync_n[i];
            end else begin
                pix_r_s       = pix_r_s;
            end
        end
    end

    // Colour forcing: black when idle, optionally scaled by the fade level
    always_comb begin
        if (!out_valid_s) begin
            out_r_s = '0;
            out_g_s = '0;
            out_b_s = '0;
        end else begin
`ifdef VGA_ARB_FADE_EN
            out_r_s = fade_scale(pix_r_s, level_nxt_s);
            out_g_s = fade_scale(pix_g_s, level_nxt_s);
            out_b_s = fade_scale(pix_b_s, level_nxt_s);
`else
            out_r_s = pix_r_s;
            out_g_s = pix_g_s;
            out_b_s = pix_b_s;
`endif
        end
    end

    // Selection FSM: decides when the displayed source changes
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state_r          <= ST_SHOW;
            active_sel_r     <= '0;
            sel_valid_r      <= 1'b0;
            switch_pending_r <= 1'b0;
`ifdef VGA_ARB_FADE_EN
            level_r          <= LVL_FULL;
`endif
        end else begin
`ifdef VGA_ARB_FADE_EN
            level_r <= level_nxt_s;
            case (state_r)
                ST_SHOW: begin
                    if (differ_s) begin
                        state_r          <= ST_FADE_OUT;
                        switch_pending_r <= 1'b1;
                    end else begin
                        state_r          <= ST_SHOW;
                    end
                end
                ST_FADE_OUT: begin
                    if (!differ_s) begin
                        state_r <= ST_FADE_IN;
                    end else if (level_nxt_s == 7'd0) begin
                        state_r <= ST_SWAP;
                    end else begin
                        state_r <= ST_FADE_OUT;
                    end
                end
                ST_SWAP: begin
                    if (boundary_s) begin
                        active_sel_r <= target_idx_s;
                        sel_valid_r  <= target_valid_s;
                        state_r      <= ST_FADE_IN;
                    end else begin
                        state_r      <= ST_SWAP;
                    end
                end
                ST_FADE_IN: begin
                    if (differ_s) begin
                        state_r          <= ST_FADE_OUT;
                    end else if (level_nxt_s == LVL_FULL) begin
                        state_r          <= ST_SHOW;
                        switch_pending_r <= 1'b0;
                    end else begin
                        state_r          <= ST_FADE_IN;
                    end
                end
                default: begin
                    state_r          <= ST_SHOW;
                    switch_pending_r <= 1'b0;
                end
            endcase
`else
            case (state_r)
                ST_SHOW: begin
                    if (differ_s) begin
                        state_r          <= ST_WAIT_VS;
                        switch_pending_r <= 1'b1;
                    end else begin
                        state_r          <= ST_SHOW;
                    end
                end
                ST_WAIT_VS: begin
                    if (!differ_s) begin
                        // request went back to what is shown: cancel
                        state_r          <= ST_SHOW;
                        switch_pending_r <= 1'b0;
                    end else if (boundary_s) begin
                        active_sel_r     <= target_idx_s;
                        sel_valid_r      <= target_valid_s;
                        state_r          <= ST_SHOW;
                        switch_pending_r <= 1'b0;
                    end else begin
                        state_r          <= ST_WAIT_VS;
                    end
                end
                default: begin
                    state_r          <= ST_SHOW;
                    switch_pending_r <= 1'b0;
                end
            endcase
`endif
        end
    end

    // Output pipeline register plus registered copy of the timing vsync
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            vga_r_r       <= '0;
            vga_g_r       <= '0;
            vga_b_r       <= '0;
            vga_hs_r      <= 1'b1;
            vga_vs_r      <= 1'b1;
            vga_blank_n_r <= 1'b0;
            vga_sync_n_r  <= 1'b0;
            vs_prev_r     <= 1'b1;
        end else begin
            vga_r_r       <= out_r_s;
            vga_g_r       <= out_g_s;
            vga_b_r       <= out_b_s;
            vga_hs_r      <= pix_hs_s;
            vga_vs_r      <= pix_vs_s;
            vga_blank_n_r <= pix_blank_n_s;
            vga_sync_n_r  <= pix_sync_n_s;
            vs_prev_r     <= bus.src_vs[time_idx_s];
        end
    end

    assign bus.VGA_R          = vga_r_r;
    assign bus.VGA_G          = vga_g_r;
    assign bus.VGA_B          = vga_b_r;
    assign bus.VGA_HS         = vga_hs_r;
    assign bus.VGA_VS         = vga_vs_r;
    assign bus.VGA_BLANK_N    = vga_blank_n_r;
    assign bus.VGA_SYNC_N     = vga_sync_n_r;
    assign bus.active_sel     = active_sel_r;
    assign bus.sel_valid      = sel_valid_r;
    assign bus.switch_pending = switch_pending_r;
endmodule

// File: tb/tb_vga_screen_arbiter.sv
// Directed testbench for vga_screen_arbiter (plain build, or fade build when
// VGA_ARB_FADE_EN is defined, then with FADE_FRAMES = 4).
module tb_vga_screen_arbiter;
    localparam int NUM_SRC = 8;
    localparam int COLOR_W = 8;
`ifdef VGA_ARB_FADE_EN
    localparam int FADE_FRAMES = 4;
`else
    localparam int FADE_FRAMES = 16;
`endif

    logic clk    = 1'b0;
    logic resetn = 1'b0;
    int   checks   = 0;
    int   failures = 0;
    logic [7:0] colour [NUM_SRC];

    vga_screen_arbiter_if #(.NUM_SRC(NUM_SRC), .COLOR_W(COLOR_W)) bus ();

    vga_screen_arbiter #(
        .NUM_SRC     (NUM_SRC),
        .COLOR_W     (COLOR_W),
        .FADE_FRAMES (FADE_FRAMES)
    ) dut (
        .CLOCK_50 (clk),
        .resetn   (resetn),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic vs_low(input logic [7:0] mask);
        bus.src_vs = ~mask;
        tick();
    endtask

    task automatic vs_high();
        bus.src_vs = 8'hFF;
        tick();
    endtask

    task automatic load_colours();
        for (int i = 0; i < NUM_SRC; i++) begin
            bus.src_r[i*8 +: 8] = colour[i];
            bus.src_g[i*8 +: 8] = ~colour[i];
            bus.src_b[i*8 +: 8] = colour[i];
        end
    endtask

    task automatic test_reset();
        resetn          = 1'b0;
        bus.src_req     = 8'h00;
        bus.src_hs      = 8'hFF;
        bus.src_vs      = 8'hFF;
        bus.src_blank_n = 8'hFF;
        bus.src_sync_n  = 8'hFF;
        load_colours();
        tick(); tick();
        checks++; if (bus.VGA_R !== 8'h00) begin failures++; $display("FAIL rst_r got=%h exp=00", bus.VGA_R); end
        checks++; if (bus.VGA_BLANK_N !== 1'b0) begin failures++; $display("FAIL rst_blank got=%b exp=0", bus.VGA_BLANK_N); end
        checks++; if (bus.VGA_SYNC_N !== 1'b0) begin failures++; $display("FAIL rst_sync got=%b exp=0", bus.VGA_SYNC_N); end
        checks++; if ({bus.VGA_HS, bus.VGA_VS} !== 2'b11) begin failures++; $display("FAIL rst_hsvs got=%b exp=11", {bus.VGA_HS, bus.VGA_VS}); end
        checks++; if ({bus.sel_valid, bus.switch_pending, bus.active_sel} !== 5'b0) begin failures++; $display("FAIL rst_status got=%b exp=00000", {bus.sel_valid, bus.switch_pending, bus.active_sel}); end
        resetn = 1'b1;
        tick();
        checks++; if (bus.VGA_BLANK_N !== 1'b1) begin failures++; $display("FAIL idle_blank got=%b exp=1", bus.VGA_BLANK_N); end
        checks++; if (bus.VGA_R !== 8'h00) begin failures++; $display("FAIL idle_black got=%h exp=00", bus.VGA_R); end
        bus.src_hs = 8'hFE;
        #1;
        checks++; if (bus.VGA_HS !== 1'b1) begin failures++; $display("FAIL hs_latency got=%b exp=1", bus.VGA_HS); end
        tick();
        checks++; if (bus.VGA_HS !== 1'b0) begin failures++; $display("FAIL hs_follow0 got=%b exp=0", bus.VGA_HS); end
        bus.src_hs = 8'h01;
        tick();
        checks++; if (bus.VGA_HS !== 1'b1) begin failures++; $display("FAIL hs_src0_only got=%b exp=1", bus.VGA_HS); end
        bus.src_hs = 8'hFF;
        vs_low(8'h01);
        checks++; if (bus.VGA_VS !== 1'b0) begin failures++; $display("FAIL vs_follow0 got=%b exp=0", bus.VGA_VS); end
        checks++; if (bus.sel_valid !== 1'b0) begin failures++; $display("FAIL idle_valid got=%b exp=0", bus.sel_valid); end
        vs_high();
    endtask

`ifndef VGA_ARB_FADE_EN
    task automatic test_switch();
        bus.src_req = 8'h04;
        tick();
        checks++; if (bus.switch_pending !== 1'b1) begin failures++; $display("FAIL sw_pending got=%b exp=1", bus.switch_pending); end
        tick(); tick();
        checks++; if (bus.VGA_R !== 8'h00 || bus.sel_valid !== 1'b0) begin failures++; $display("FAIL sw_wait got r=%h v=%b exp r=00 v=0", bus.VGA_R, bus.sel_valid); end
        vs_low(8'h04);
        checks++; if (bus.sel_valid !== 1'b0) begin failures++; $display("FAIL sw_wrong_vs got=%b exp=0", bus.sel_valid); end
        vs_high();
        vs_low(8'h01);
        checks++; if (bus.active_sel !== 3'd2 || bus.sel_valid !== 1'b1) begin failures++; $display("FAIL sw_sel got=%0d/%b exp=2/1", bus.active_sel, bus.sel_valid); end
        checks++; if (bus.VGA_R !== 8'hAA) begin failures++; $display("FAIL sw_r got=%h exp=AA", bus.VGA_R); end
        checks++; if (bus.VGA_G !== 8'h55) begin failures++; $display("FAIL sw_g got=%h exp=55", bus.VGA_G); end
        checks++; if (bus.switch_pending !== 1'b0) begin failures++; $display("FAIL sw_clear got=%b exp=0", bus.switch_pending); end
        vs_high();
    endtask

    task automatic test_priority();
        bus.src_req = 8'h14;
        tick();
        checks++; if (bus.switch_pending !== 1'b0 || bus.active_sel !== 3'd2) begin failures++; $display("FAIL pri_keep got=%b/%0d exp=0/2", bus.switch_pending, bus.active_sel); end
        bus.src_req = 8'h10;
        tick();
        checks++; if (bus.switch_pending !== 1'b1) begin failures++; $display("FAIL pri_pending got=%b exp=1", bus.switch_pending); end
        vs_low(8'h01);
        checks++; if (bus.active_sel !== 3'd2) begin failures++; $display("FAIL pri_vs0 got=%0d exp=2", bus.active_sel); end
        vs_high();
        vs_low(8'h10);
        checks++; if (bus.active_sel !== 3'd2) begin failures++; $display("FAIL pri_vs4 got=%0d exp=2", bus.active_sel); end
        vs_high();
        vs_low(8'h04);
        checks++; if (bus.active_sel !== 3'd4 || bus.VGA_R !== 8'h55) begin failures++; $display("FAIL pri_swap got=%0d/%h exp=4/55", bus.active_sel, bus.VGA_R); end
        checks++; if (bus.switch_pending !== 1'b0) begin failures++; $display("FAIL pri_clear got=%b exp=0", bus.switch_pending); end
        vs_high();
    endtask

    task automatic test_cancel();
        bus.src_req = 8'h04;
        tick();
        vs_low(8'h10);
        checks++; if (bus.active_sel !== 3'd2) begin failures++; $display("FAIL can_setup got=%0d exp=2", bus.active_sel); end
        vs_high();
        bus.src_req = 8'h20;
        tick();
        checks++; if (bus.switch_pending !== 1'b1 || bus.VGA_R !== 8'hAA) begin failures++; $display("FAIL can_pend got=%b/%h exp=1/AA", bus.switch_pending, bus.VGA_R); end
        bus.src_req = 8'h04;
        tick();
        checks++; if (bus.switch_pending !== 1'b0) begin failures++; $display("FAIL can_clear got=%b exp=0", bus.switch_pending); end
        vs_low(8'h04);
        checks++; if (bus.active_sel !== 3'd2 || bus.VGA_R !== 8'hAA) begin failures++; $display("FAIL can_noswap got=%0d/%h exp=2/AA", bus.active_sel, bus.VGA_R); end
        vs_high();
    endtask

    task automatic test_retarget();
        bus.src_req = 8'h40;
        tick();
        bus.src_req = 8'h08;
        tick();
        checks++; if (bus.switch_pending !== 1'b1 || bus.active_sel !== 3'd2) begin failures++; $display("FAIL rt_pend got=%b/%0d exp=1/2", bus.switch_pending, bus.active_sel); end
        vs_low(8'h04);
        checks++; if (bus.active_sel !== 3'd3 || bus.VGA_R !== 8'h44) begin failures++; $display("FAIL rt_swap got=%0d/%h exp=3/44", bus.active_sel, bus.VGA_R); end
        vs_high();
    endtask

    task automatic test_async_reset();
        bus.src_req = 8'h01;
        tick();
        checks++; if (bus.switch_pending !== 1'b1 || bus.VGA_R !== 8'h44) begin failures++; $display("FAIL ar_pre got=%b/%h exp=1/44", bus.switch_pending, bus.VGA_R); end
        #2 resetn = 1'b0;
        #1;
        checks++; if (bus.VGA_R !== 8'h00 || bus.VGA_BLANK_N !== 1'b0 || bus.VGA_SYNC_N !== 1'b0) begin failures++; $display("FAIL ar_out got=%h/%b/%b exp=00/0/0", bus.VGA_R, bus.VGA_BLANK_N, bus.VGA_SYNC_N); end
        checks++; if ({bus.sel_valid, bus.switch_pending, bus.active_sel} !== 5'b0) begin failures++; $display("FAIL ar_status got=%b exp=00000", {bus.sel_valid, bus.switch_pending, bus.active_sel}); end
        tick();
        resetn = 1'b1;
        tick();
    endtask
`else
    task automatic test_fade();
        logic [7:0] exp_r [9];
        exp_r = '{8'hBF, 8'h7F, 8'h3F, 8'h00, 8'h00, 8'h3F, 8'h7F, 8'hBF, 8'hFF};
        bus.src_req = 8'h02;
        tick();
        for (int n = 0; n < 12; n++) begin
            vs_low(8'hFF);
            vs_high();
            if (bus.switch_pending == 1'b0) break;
        end
        checks++; if (bus.active_sel !== 3'd1 || bus.sel_valid !== 1'b1 || bus.VGA_R !== 8'hFF) begin failures++; $display("FAIL fd_setup got=%0d/%b/%h exp=1/1/FF", bus.active_sel, bus.sel_valid, bus.VGA_R); end
        bus.src_req = 8'h04;
        tick();
        checks++; if (bus.switch_pending !== 1'b1 || bus.VGA_R !== 8'hFF) begin failures++; $display("FAIL fd_start got=%b/%h exp=1/FF", bus.switch_pending, bus.VGA_R); end
        for (int k = 0; k < 9; k++) begin
            vs_low(8'hFF);
            checks++; if (bus.VGA_R !== exp_r[k]) begin failures++; $display("FAIL fd_step%0d got=%h exp=%h", k, bus.VGA_R, exp_r[k]); end
            checks++; if (bus.switch_pending !== (k < 8)) begin failures++; $display("FAIL fd_pend%0d got=%b exp=%b", k, bus.switch_pending, (k < 8)); end
            vs_high();
            checks++; if (bus.VGA_R !== exp_r[k]) begin failures++; $display("FAIL fd_hold%0d got=%h exp=%h", k, bus.VGA_R, exp_r[k]); end
        end
        checks++; if (bus.active_sel !== 3'd2) begin failures++; $display("FAIL fd_sel got=%0d exp=2", bus.active_sel); end
    endtask
`endif

    initial begin
        colour = '{8'h11, 8'h22, 8'hAA, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
`ifdef VGA_ARB_FADE_EN
        colour[1] = 8'hFF;
        colour[2] = 8'hFF;
`endif
        test_reset();
`ifdef VGA_ARB_FADE_EN
        test_fade();
`else
        test_switch();
        test_priority();
        test_cancel();
        test_retarget();
        test_async_reset();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish within time limit");
        $fatal(1, "watchdog expired");
    end
endmodule
